// File: rtl/ntt_pkg.sv
// Shared constants and types for the ntt accelerator and its host DMA.
// Accelerator address map, transform modes and the DMA FSM encoding.
package ntt_pkg;

    localparam int N             = 256;
    localparam int NTT_CFG_ADDR  = 1;
    localparam int NTT_DATA_ADDR = 0;

    typedef enum logic [1:0] {
        KYBER_NTT  = 2'b00,
        KYBER_INTT = 2'b01,
        DIL_NTT    = 2'b10,
        DIL_INTT   = 2'b11
    } ntt_mode_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CFG     = 3'd1,
        S_LOAD    = 3'd2,
        S_COLLECT = 3'd3,
        S_DONE    = 3'd4
    } dma_state_e;

endpackage

// File: rtl/ntt_host_dma.sv
// Host-side bus master for one ntt instance: config write, coefficient
// stream from the source RAM, result collection into the destination RAM.
module ntt_host_dma
    import ntt_pkg::*;
#(
    parameter int N       = ntt_pkg::N,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MAW     = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic           dma_clk_i,
    input  logic           dma_rst_ni,
    input  logic           start_i,
    input  logic [1:0]     mode_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o,
    output logic [MAW-1:0] src_addr_o,
    input  logic [DW-1:0]  src_rdata_i,
    output logic           dst_we_o,
    output logic [MAW-1:0] dst_addr_o,
    output logic [DW-1:0]  dst_wdata_o,
    output logic           ntt_we_o,
    output logic [AW-1:0]  ntt_addr_o,
    output logic [DW-1:0]  ntt_wdata_o,
    input  logic           ntt_rvalid_i,
    input  logic [DW-1:0]  ntt_rdata_i
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    dma_state_e     r_state;
    ntt_mode_e      r_mode;
    logic [CW-1:0]  r_cnt;
    logic [IW-1:0]  r_idle;
    logic           r_err;
    logic [MAW-1:0] r_src_addr;
    logic           r_dst_we;
    logic [MAW-1:0] r_dst_addr;
    logic [DW-1:0]  r_dst_wdata;

    logic           w_last_load;
    logic           w_all_res;
    logic           w_timeout;
    logic [DW-1:0]  w_ntt_wdata;

    assign w_last_load = (r_cnt == CW'(N - 1));
    assign w_all_res   = (r_cnt == CW'(N));
    assign w_timeout   = (r_idle == IW'(TIMEOUT - 1));

    // FSM, beat/idle counters and the registered RAM-side outputs.
    // The beat counter walks the stream in LOAD, then counts results in
    // COLLECT; reaching N holds COLLECT one extra cycle so done follows
    // the final destination write.
    always_ff @(posedge dma_clk_i) begin
        if (!dma_rst_ni) begin
            r_state     <= S_IDLE;
            r_mode      <= KYBER_NTT;
            r_cnt       <= '0;
            r_idle      <= '0;
            r_err       <= 1'b0;
            r_src_addr  <= '0;
            r_dst_we    <= 1'b0;
            r_dst_addr  <= '0;
            r_dst_wdata <= '0;
        end else begin
            r_dst_we   <= 1'b0;
            r_src_addr <= '0;
            if (ntt_rvalid_i && r_state != S_COLLECT) begin
                r_err <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_mode  <= ntt_mode_e'(mode_i);
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_idle  <= '0;
                        r_state <= S_CFG;
                    end
                end
                S_CFG: begin
                    r_src_addr <= MAW'(1);
                    r_state    <= S_LOAD;
                end
                S_LOAD: begin
                    if (w_last_load) begin
                        r_cnt   <= '0;
                        r_state <= S_COLLECT;
                    end else begin
                        r_cnt      <= r_cnt + CW'(1);
                        r_src_addr <= r_src_addr + MAW'(1);
                    end
                end
                S_COLLECT: begin
                    if (w_all_res) begin
                        if (ntt_rvalid_i) begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else if (ntt_rvalid_i) begin
                        r_dst_we    <= 1'b1;
                        r_dst_addr  <= r_cnt[MAW-1:0];
                        r_dst_wdata <= ntt_rdata_i;
                        r_cnt       <= r_cnt + CW'(1);
                        r_idle      <= '0;
                    end else if (w_timeout) begin
                        r_idle  <= IW'(TIMEOUT);
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idle <= r_idle + IW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Accelerator write data: config word in CFG, RAM output during LOAD.
    always_comb begin
        w_ntt_wdata = '0;
        if (r_state == S_CFG) begin
            w_ntt_wdata = {{(DW-2){1'b0}}, r_mode};
        end else if (r_state == S_LOAD) begin
            w_ntt_wdata = src_rdata_i;
        end
    end

    assign busy_o      = (r_state == S_CFG) || (r_state == S_LOAD) ||
                         (r_state == S_COLLECT);
    assign done_o      = (r_state == S_DONE);
    assign err_o       = r_err;
    assign src_addr_o  = r_src_addr;
    assign dst_we_o    = r_dst_we;
    assign dst_addr_o  = r_dst_addr;
    assign dst_wdata_o = r_dst_wdata;
    assign ntt_we_o    = (r_state == S_CFG) || (r_state == S_LOAD);
    assign ntt_addr_o  = (r_state == S_CFG) ? AW'(NTT_CFG_ADDR) :
                                              AW'(NTT_DATA_ADDR);
    assign ntt_wdata_o = w_ntt_wdata;

endmodule

// File: tb/tb_ntt_host_dma.sv
// Self-checking bench for ntt_host_dma: source RAM model, bus and
// destination-RAM logs, and a scripted accelerator responder.
module tb_ntt_host_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        busy, done, err;
    logic [7:0]  src_addr;
    logic [31:0] src_q = '0;
    logic        dst_we;
    logic [7:0]  dst_addr;
    logic [31:0] dst_wdata;
    logic        ntt_we;
    logic [31:0] ntt_addr, ntt_wdata;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    ntt_host_dma #(.TIMEOUT(64)) dut (
        .dma_clk_i(clk), .dma_rst_ni(rst_n),
        .start_i(start), .mode_i(mode),
        .busy_o(busy), .done_o(done), .err_o(err),
        .src_addr_o(src_addr), .src_rdata_i(src_q),
        .dst_we_o(dst_we), .dst_addr_o(dst_addr), .dst_wdata_o(dst_wdata),
        .ntt_we_o(ntt_we), .ntt_addr_o(ntt_addr), .ntt_wdata_o(ntt_wdata),
        .ntt_rvalid_i(rvalid), .ntt_rdata_i(rdata)
    );

    logic [31:0] src_mem [256];

    // Source RAM with one-cycle registered read.
    always @(posedge clk) src_q <= src_mem[src_addr];

    int          cyc = 0;
    int          bus_n = 0;
    int          dst_n = 0;
    int          done_n = 0;
    logic [31:0] bus_addr [4096];
    logic [31:0] bus_data [4096];
    int          bus_cyc [4096];
    logic [7:0]  dst_addr_l [4096];
    logic [31:0] dst_data_l [4096];

    // Logs every accelerator write, destination write and done pulse.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ntt_we && bus_n < 4096) begin
            bus_addr[bus_n] <= ntt_addr;
            bus_data[bus_n] <= ntt_wdata;
            bus_cyc[bus_n]  <= cyc;
            bus_n           <= bus_n + 1;
        end
        if (dst_we && dst_n < 4096) begin
            dst_addr_l[dst_n] <= dst_addr;
            dst_data_l[dst_n] <= dst_wdata;
            dst_n             <= dst_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    typedef struct {
        logic [1:0]  mode;
        bit          echo;
        int          gap;
        int          offs;
        int          nres;
        bit          spur;
        bit          restart;
        bit          pre_rst;
        logic [31:0] exp_cfg;
        int          exp_wr;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic bit outs_zero();
        return !busy && !done && !err && src_addr == 8'd0 && !dst_we &&
               dst_addr == 8'd0 && dst_wdata == 32'd0 && !ntt_we &&
               ntt_addr == 32'd0 && ntt_wdata == 32'd0;
    endfunction

    task automatic reset_mid_load();
        int dn, db, bn, bad;
        @(negedge clk);
        mode  = 2'b10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (51) @(negedge clk);
        chk("beat50_addr", ntt_addr, 0);
        chk("beat50_data", ntt_wdata, 50);
        dn = done_n;
        db = dst_n;
        rst_n = 1'b0;
        @(negedge clk);
        bn = bus_n;
        chk("midrst_outs_zero", outs_zero(), 1);
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (ntt_we || dst_we || done) bad++;
        end
        chk("midrst_quiet", bad, 0);
        chk("midrst_no_bus", bus_n - bn, 0);
        chk("midrst_no_done", done_n - dn, 0);
        chk("midrst_no_dst", dst_n - db, 0);
    endtask

    task automatic run_txn(input vec_t v);
        int bb, db, dn, lat, bad;
        bit ok;
        logic [31:0] exp_d;
        bb = bus_n;
        db = dst_n;
        dn = done_n;
        @(negedge clk);
        mode  = v.mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rvalid = v.spur && (i == 100);
            if (busy && !ntt_we) begin
                ok = 1'b1;
                break;
            end
        end
        rvalid = 1'b0;
        chk("reach_collect", ok, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = v.restart && (i == 3);
        end
        start = 1'b0;
        for (int k = 0; k < v.nres; k++) begin
            @(negedge clk);
            rvalid = 1'b1;
            rdata  = v.echo ? bus_data[bb + 1 + k] : 32'(v.offs + k);
            if (k != v.nres - 1) begin
                for (int g = 0; g < v.gap; g++) begin
                    @(negedge clk);
                    rvalid = 1'b0;
                end
            end
        end
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rvalid = 1'b0;
            lat++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", ok, 1);
        chk("done_latency", lat, v.exp_lat);
        chk("err_at_done", err, v.exp_err);
        chk("busy_at_done", busy, 0);
        repeat (3) @(negedge clk);
        chk("bus_beats", bus_n - bb, 257);
        chk("cfg_addr", bus_addr[bb], 1);
        chk("cfg_data", bus_data[bb], v.exp_cfg);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (bus_addr[bb + 1 + k] !== 32'd0 ||
                bus_data[bb + 1 + k] !== src_mem[k]) bad++;
        end
        chk("load_data_bad", bad, 0);
        chk("load_contiguous", bus_cyc[bb + 256] - bus_cyc[bb], 256);
        chk("dst_writes", dst_n - db, v.exp_wr);
        bad = 0;
        for (int k = 0; k < v.exp_wr; k++) begin
            exp_d = v.echo ? src_mem[k] : 32'(v.offs + k);
            if (dst_addr_l[db + k] !== 8'(k) ||
                dst_data_l[db + k] !== exp_d) bad++;
        end
        chk("dst_data_bad", bad, 0);
        chk("done_pulses", done_n - dn, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int bad;
        //          mode  echo gap offs nres spur rst pre  cfg  wr  err lat
        vecs[0] = '{2'b10, 1, 0,    0, 256, 0, 0, 0, 32'd2, 256, 1'b0,  2};
        vecs[1] = '{2'b00, 0, 2, 1000, 256, 0, 0, 0, 32'd0, 256, 1'b0,  2};
        vecs[2] = '{2'b11, 0, 0, 5000, 100, 0, 0, 0, 32'd3, 100, 1'b1, 65};
        vecs[3] = '{2'b01, 1, 0,    0, 256, 1, 1, 0, 32'd1, 256, 1'b1,  2};
        vecs[4] = '{2'b01, 1, 0,    0, 256, 0, 0, 1, 32'd1, 256, 1'b0,  2};
        for (int i = 0; i < 256; i++) src_mem[i] = 32'(i);

        rst_n = 1'b0;
        start = 1'b1;
        mode  = 2'b11;
        bad   = 0;
        repeat (4) begin
            @(negedge clk);
            if (!outs_zero()) bad++;
        end
        chk("reset_outs_zero", bad, 0);
        chk("reset_no_bus", bus_n, 0);
        chk("reset_no_dst", dst_n, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].pre_rst) reset_mid_load();
            run_txn(vecs[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
